// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_if
// Description : Request/response bundle between the core control path and
//               the data-memory responder.
//               master : control path (drives requests, receives results)
//               slave  : data_mem_responder
//   memRead / memWrite : load / store request strobes
//   funct3             : access size and sign (b, h, w, bu, hu)
//   addr / writeData   : byte address and store data
//   readData           : registered load result
//   memReady           : one-cycle completion pulse
//   memBusy            : request in flight
//   memError           : request rejected (valid with memReady)
// Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        memReady;
  logic        memBusy;
  logic        memError;

  modport master (
    output memRead, memWrite, funct3, addr, writeData,
    input  readData, memReady, memBusy, memError
  );

  modport slave (
    input  memRead, memWrite, funct3, addr, writeData,
    output readData, memReady, memBusy, memError
  );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Multicycle data-memory responder. Accepts one load/store in
//               IDLE, waits LATENCY cycles, then commits against an internal
//               word array with RV32 lane selection, sign/zero extension and
//               store lane merging, and returns a one-cycle memReady pulse.
// Ports       : clk      - sole clock, rising edge
//               rst      - synchronous active-high reset
//               mem_bus  - data_mem_responder_if.slave request/response bundle
// Parameters  : ADDR_WIDTH - word-address bits (2^ADDR_WIDTH 32-bit words)
//               LATENCY    - wait cycles before commit (0..15)
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int ADDR_WIDTH = 8,
  parameter int LATENCY    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  data_mem_responder_if.slave   mem_bus
);

  localparam int         c_DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [3:0] c_CNT_INIT = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_RESPOND = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [2:0]            f3_q;
  logic                  write_q;
  logic                  err_q;
  logic [31:0]           rdata_q;
  logic [31:0]           mem_q [c_DEPTH];

  logic                  w_req;
  logic                  w_req_err;
  logic                  w_commit;
  logic [ADDR_WIDTH+1:0] w_c_addr;
  logic [31:0]           w_c_wdata;
  logic [2:0]            w_c_f3;
  logic                  w_c_write;
  logic                  w_c_err;
  logic [ADDR_WIDTH-1:0] w_c_idx;
  logic [31:0]           w_word;
  logic [7:0]            w_byte;
  logic [15:0]           w_half;
  logic [31:0]           w_load;
  logic [31:0]           w_merged;
  logic                  w_unused_addr_hi;

  // Upper address bits are deliberately ignored so the array wraps.
  assign w_unused_addr_hi = ^mem_bus.addr[31:ADDR_WIDTH+2];

  assign w_req = mem_bus.memRead | mem_bus.memWrite;

  // Rejection verdict, evaluated on the live request while in IDLE.
  always_comb begin
    w_req_err = 1'b0;
    if (mem_bus.memRead && mem_bus.memWrite)
      w_req_err = 1'b1;
    if (mem_bus.funct3[1:0] == 2'b01 && mem_bus.addr[0])
      w_req_err = 1'b1;
    if (mem_bus.funct3[1:0] == 2'b10 && mem_bus.addr[1:0] != 2'b00)
      w_req_err = 1'b1;
    if (mem_bus.memWrite && !(mem_bus.funct3 inside {3'b000, 3'b001, 3'b010}))
      w_req_err = 1'b1;
    if (!mem_bus.memWrite && (mem_bus.funct3 inside {3'b011, 3'b110, 3'b111}))
      w_req_err = 1'b1;
  end

  // With zero latency the commit happens on the accepting edge, so the
  // commit operands come straight from the bus while in IDLE.
  always_comb begin
    if (state_q == S_IDLE) begin
      w_c_addr  = mem_bus.addr[ADDR_WIDTH+1:0];
      w_c_wdata = mem_bus.writeData;
      w_c_f3    = mem_bus.funct3;
      w_c_write = mem_bus.memWrite;
      w_c_err   = w_req_err;
    end else begin
      w_c_addr  = addr_q;
      w_c_wdata = wdata_q;
      w_c_f3    = f3_q;
      w_c_write = write_q;
      w_c_err   = err_q;
    end
  end

  // Lane selection, load extension and store merge on the addressed word.
  always_comb begin
    w_c_idx  = w_c_addr[ADDR_WIDTH+1:2];
    w_word   = mem_q[w_c_idx];
    w_byte   = w_word[{w_c_addr[1:0], 3'b000} +: 8];
    w_half   = w_c_addr[1] ? w_word[31:16] : w_word[15:0];
    case (w_c_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = w_word;
    endcase
    w_merged = w_word;
    case (w_c_f3)
      3'b000:  w_merged[{w_c_addr[1:0], 3'b000} +: 8] = w_c_wdata[7:0];
      3'b001:  w_merged[{w_c_addr[1], 4'b0000} +: 16] = w_c_wdata[15:0];
      default: w_merged = w_c_wdata;
    endcase
  end

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    w_commit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          if (LATENCY == 0) begin
            state_d  = S_RESPOND;
            w_commit = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = c_CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d  = S_RESPOND;
          w_commit = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESPOND: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      f3_q    <= 3'd0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == S_IDLE && w_req) begin
        addr_q  <= mem_bus.addr[ADDR_WIDTH+1:0];
        wdata_q <= mem_bus.writeData;
        f3_q    <= mem_bus.funct3;
        write_q <= mem_bus.memWrite;
        err_q   <= w_req_err;
      end
      if (w_commit) begin
        if (w_c_err)
          rdata_q <= 32'd0;
        else if (!w_c_write)
          rdata_q <= w_load;
      end
    end
  end

  // Array has no reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && w_c_write && !w_c_err)
      mem_q[w_c_idx] <= w_merged;
  end

  assign mem_bus.readData = rdata_q;
  assign mem_bus.memReady = (state_q == S_RESPOND);
  assign mem_bus.memBusy  = (state_q != S_IDLE);
  assign mem_bus.memError = (state_q == S_RESPOND) && err_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_mem_responder
// Description : Self-checking bench for data_mem_responder. Two instances
//               (LATENCY=2 and LATENCY=0) share clk/rst. Directed table,
//               hand-written corner sequences and random traffic checked
//               against an array-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_responder_if b2();
  data_mem_responder_if b0();

  data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(2)) u_dut2 (.clk(clk), .rst(rst), .mem_bus(b2));
  data_mem_responder #(.ADDR_WIDTH(8), .LATENCY(0)) u_dut0 (.clk(clk), .rst(rst), .mem_bus(b0));

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: per-instance word arrays and last readData.
  logic [31:0] mm  [2][256];
  logic [31:0] mrd [2];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eerr;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    end
  endtask

  function automatic vec_t mkv(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic [31:0] erd, input logic eerr);
    vec_t v;
    v.rd = rd; v.wr = wr; v.f3 = f3; v.a = a; v.wd = wd; v.erd = erd; v.eerr = eerr;
    return v;
  endfunction

  function automatic logic m_err(input logic rd, input logic wr, input logic [2:0] f3, input logic [31:0] a);
    if (rd && wr) return 1'b1;
    if ((f3 == 3'd1 || f3 == 3'd5) && (a % 32'd2) != 32'd0) return 1'b1;
    if (f3 == 3'd2 && (a % 32'd4) != 32'd0) return 1'b1;
    if (wr && f3 > 3'd2) return 1'b1;
    if (!wr && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 32'd4))) & 32'hFF;
    h = (w >> (16 * ((a / 32'd2) % 32'd2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b - 32'd256   : b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] w, input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] wd);
    logic [31:0] sh, mask;
    case (f3)
      3'd0:    begin sh = 8 * (a % 32'd4);                mask = 32'hFF << sh;   end
      3'd1:    begin sh = 16 * ((a / 32'd2) % 32'd2);     mask = 32'hFFFF << sh; end
      default: begin sh = 32'd0;                          mask = 32'hFFFFFFFF;   end
    endcase
    return (w & ~mask) | ((wd << sh) & mask);
  endfunction

  task automatic model_txn(input bit sel, input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd,
                           output logic [31:0] erd, output logic eerr);
    int idx;
    idx  = int'((a / 32'd4) % 32'd256);
    eerr = m_err(rd, wr, f3, a);
    if (eerr)    mrd[sel] = 32'd0;
    else if (wr) mm[sel][idx] = m_store(mm[sel][idx], f3, a, wd);
    else         mrd[sel] = m_load(mm[sel][idx], f3, a);
    erd = mrd[sel];
  endtask

  task automatic drive(input bit sel, input logic rd, input logic wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd);
    if (sel) begin
      b0.memRead = rd; b0.memWrite = wr; b0.funct3 = f3; b0.addr = a; b0.writeData = wd;
    end else begin
      b2.memRead = rd; b2.memWrite = wr; b2.funct3 = f3; b2.addr = a; b2.writeData = wd;
    end
  endtask

  function automatic logic rdy(input bit sel);   return sel ? b0.memReady : b2.memReady; endfunction
  function automatic logic busy(input bit sel);  return sel ? b0.memBusy  : b2.memBusy;  endfunction
  function automatic logic errf(input bit sel);  return sel ? b0.memError : b2.memError; endfunction
  function automatic logic [31:0] rdat(input bit sel); return sel ? b0.readData : b2.readData; endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic do_req(input bit sel, input logic rd, input logic wr, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic [31:0] grd, output logic gerr, output int lat);
    drive(sel, rd, wr, f3, a, wd);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, f3, a, wd);
    lat = 0;
    while (!rdy(sel) && lat < 20) begin
      chk1("busy_in_wait", busy(sel), 1'b1);
      chk1("error_without_ready", errf(sel), 1'b0);
      @(negedge clk);
      lat++;
    end
    chk1("busy_in_respond", busy(sel), 1'b1);
    grd  = rdat(sel);
    gerr = errf(sel);
    @(negedge clk);
    chk1("ready_single_pulse", rdy(sel), 1'b0);
    chk1("busy_after_respond", busy(sel), 1'b0);
  endtask

  task automatic rand_txn(input bit sel);
    logic        rd, wr, eerr, gerr;
    logic [2:0]  f3;
    logic [31:0] a, wd, erd, grd;
    int          k, lat;
    k  = int'($urandom_range(0, 19));
    rd = (k < 9) || (k == 19);
    wr = (k >= 9);
    if ($urandom_range(0, 9) == 0) f3 = 3'($urandom_range(0, 7));
    else if (wr)                   f3 = 3'($urandom_range(0, 2));
    else begin
      case ($urandom_range(0, 4))
        0:       f3 = 3'd0;
        1:       f3 = 3'd1;
        2:       f3 = 3'd2;
        3:       f3 = 3'd4;
        default: f3 = 3'd5;
      endcase
    end
    a = ($urandom & 32'hFFFFFC00) | (32'($urandom_range(0, 15)) << 2);
    if ($urandom_range(0, 7) == 0)  a = a | 32'($urandom_range(1, 3));
    else if (f3[1:0] == 2'b00)      a = a | 32'($urandom_range(0, 3));
    else if (f3[1:0] == 2'b01)      a = a | 32'(2 * $urandom_range(0, 1));
    wd = $urandom;
    model_txn(sel, rd, wr, f3, a, wd, erd, eerr);
    do_req(sel, rd, wr, f3, a, wd, grd, gerr, lat);
    chk1("rand_error", gerr, eerr);
    check("rand_readData", grd, erd);
    check("rand_latency", 32'(lat), sel ? 32'd0 : 32'd2);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] erd, grd;
    logic        eerr, gerr;
    int          lat, n_rdy;

    for (int i = 0; i < 256; i++) begin
      mm[0][i] = 32'd0;
      mm[1][i] = 32'd0;
    end
    mrd[0] = 32'd0;
    mrd[1] = 32'd0;

    // ---- Reset with a pending load held high ----
    rst = 1'b1;
    drive(1'b0, 1'b1, 1'b0, 3'd2, 32'h0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 3'd2, 32'h0, 32'h0);
    for (int j = 0; j < 2; j++) begin
      @(negedge clk);
      chk1("rst_ready2", b2.memReady, 1'b0);
      chk1("rst_busy2", b2.memBusy, 1'b0);
      chk1("rst_error2", b2.memError, 1'b0);
      check("rst_readData2", b2.readData, 32'd0);
      chk1("rst_ready0", b0.memReady, 1'b0);
      chk1("rst_busy0", b0.memBusy, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    chk1("acc_busy2", b2.memBusy, 1'b1);
    chk1("acc_ready2", b2.memReady, 1'b0);
    chk1("acc_ready0", b0.memReady, 1'b1);
    drive(1'b0, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 3'd2, 32'h0, 32'h0);
    @(negedge clk);
    chk1("acc_ready0_off", b0.memReady, 1'b0);
    chk1("acc_busy0_off", b0.memBusy, 1'b0);
    chk1("acc_ready2_k1", b2.memReady, 1'b0);
    @(negedge clk);
    chk1("acc_ready2_k2", b2.memReady, 1'b1);
    chk1("acc_error2", b2.memError, 1'b0);
    check("acc_readData2", b2.readData, 32'd0);
    @(negedge clk);
    chk1("acc_idle2", b2.memBusy, 1'b0);

    // ---- Directed table on the LATENCY=2 instance ----
    tbl[0]  = mkv(1'b0, 1'b1, 3'd2, 32'h10,  32'hDEADBEEF, 32'h00000000, 1'b0);
    tbl[1]  = mkv(1'b1, 1'b0, 3'd2, 32'h10,  32'h0,        32'hDEADBEEF, 1'b0);
    tbl[2]  = mkv(1'b0, 1'b1, 3'd0, 32'h13,  32'h80,       32'hDEADBEEF, 1'b0);
    tbl[3]  = mkv(1'b1, 1'b0, 3'd0, 32'h13,  32'h0,        32'hFFFFFF80, 1'b0);
    tbl[4]  = mkv(1'b1, 1'b0, 3'd4, 32'h13,  32'h0,        32'h00000080, 1'b0);
    tbl[5]  = mkv(1'b1, 1'b0, 3'd2, 32'h10,  32'h0,        32'h80ADBEEF, 1'b0);
    tbl[6]  = mkv(1'b0, 1'b1, 3'd1, 32'h12,  32'h1234,     32'h80ADBEEF, 1'b0);
    tbl[7]  = mkv(1'b1, 1'b0, 3'd1, 32'h12,  32'h0,        32'h00001234, 1'b0);
    tbl[8]  = mkv(1'b1, 1'b0, 3'd2, 32'h10,  32'h0,        32'h1234BEEF, 1'b0);
    tbl[9]  = mkv(1'b1, 1'b0, 3'd2, 32'h11,  32'h0,        32'h00000000, 1'b1);
    tbl[10] = mkv(1'b0, 1'b1, 3'd1, 32'h13,  32'hFFFF,     32'h00000000, 1'b1);
    tbl[11] = mkv(1'b1, 1'b1, 3'd2, 32'h10,  32'h0,        32'h00000000, 1'b1);
    tbl[12] = mkv(1'b1, 1'b0, 3'd3, 32'h10,  32'h0,        32'h00000000, 1'b1);
    tbl[13] = mkv(1'b1, 1'b0, 3'd2, 32'h10,  32'h0,        32'h1234BEEF, 1'b0);
    tbl[14] = mkv(1'b0, 1'b1, 3'd2, 32'h400, 32'hCAFEF00D, 32'h1234BEEF, 1'b0);
    tbl[15] = mkv(1'b1, 1'b0, 3'd2, 32'h000, 32'h0,        32'hCAFEF00D, 1'b0);
    tbl[16] = mkv(1'b1, 1'b0, 3'd5, 32'h402, 32'h0,        32'h0000CAFE, 1'b0);
    tbl[17] = mkv(1'b1, 1'b0, 3'd0, 32'h401, 32'h0,        32'hFFFFFFF0, 1'b0);
    tbl[18] = mkv(1'b0, 1'b1, 3'd4, 32'h000, 32'h0,        32'h00000000, 1'b1);
    tbl[19] = mkv(1'b1, 1'b0, 3'd1, 32'h002, 32'h0,        32'hFFFFCAFE, 1'b0);
    for (int i = 0; i < 20; i++) begin
      model_txn(1'b0, tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd, erd, eerr);
      do_req(1'b0, tbl[i].rd, tbl[i].wr, tbl[i].f3, tbl[i].a, tbl[i].wd, grd, gerr, lat);
      chk1($sformatf("tbl%0d_error", i), gerr, tbl[i].eerr);
      check($sformatf("tbl%0d_readData", i), grd, tbl[i].erd);
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'd2);
    end

    // ---- Request pulsed during WAIT is ignored ----
    model_txn(1'b0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0, erd, eerr);
    drive(1'b0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b1, 3'd2, 32'h10, 32'h0);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'd2, 32'h10, 32'h0);
    n_rdy = 0;
    for (int j = 0; j < 7; j++) begin
      if (b2.memReady) begin
        n_rdy++;
        check("ignore_readData", b2.readData, erd);
      end
      @(negedge clk);
    end
    check("ignore_ready_count", 32'(n_rdy), 32'd1);
    model_txn(1'b0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0, erd, eerr);
    do_req(1'b0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0, grd, gerr, lat);
    check("ignore_mem_unchanged", grd, erd);

    // ---- Reset aborts an in-flight store ----
    drive(1'b0, 1'b0, 1'b1, 3'd2, 32'h10, 32'h55AA55AA);
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 3'd2, 32'h10, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    mrd[0] = 32'd0;
    mrd[1] = 32'd0;
    n_rdy = 0;
    for (int j = 0; j < 4; j++) begin
      if (b2.memReady) n_rdy++;
      @(negedge clk);
    end
    check("abort_ready_count", 32'(n_rdy), 32'd0);
    chk1("abort_busy", b2.memBusy, 1'b0);
    check("abort_readData", b2.readData, 32'd0);
    model_txn(1'b0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0, erd, eerr);
    do_req(1'b0, 1'b1, 1'b0, 3'd2, 32'h10, 32'h0, grd, gerr, lat);
    check("abort_mem_unchanged", grd, 32'h1234BEEF);

    // ---- LATENCY=0 instance ----
    model_txn(1'b1, 1'b0, 1'b1, 3'd2, 32'h8, 32'h0BADF00D, erd, eerr);
    do_req(1'b1, 1'b0, 1'b1, 3'd2, 32'h8, 32'h0BADF00D, grd, gerr, lat);
    check("lat0_store_latency", 32'(lat), 32'd0);
    model_txn(1'b1, 1'b1, 1'b0, 3'd2, 32'h8, 32'h0, erd, eerr);
    do_req(1'b1, 1'b1, 1'b0, 3'd2, 32'h8, 32'h0, grd, gerr, lat);
    check("lat0_load_readData", grd, 32'h0BADF00D);
    check("lat0_load_latency", 32'(lat), 32'd0);

    // ---- Random traffic against the model ----
    for (int i = 0; i < 150; i++) rand_txn(1'b0);
    for (int i = 0; i < 100; i++) rand_txn(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
